// File: rtl/router_input_arbiter.sv
// Router input arbiter with a single-entry output buffer. Picks one requester per cycle.
// Define ROUTER_ARB_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module router_input_arbiter #(
  parameter int p_nbits   = 8,
  parameter int p_ninputs = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [p_ninputs-1:0]           valid_in,
  output logic [p_ninputs-1:0]           ready_out,
  input  logic [p_nbits*p_ninputs-1:0]   message_in,
  output logic                           valid_out,
  input  logic                           ready_in,
  output logic [p_nbits-1:0]             message_out,
  output logic [$clog2(p_ninputs)-1:0]   grant_id
);
  localparam int IW = $clog2(p_ninputs);
  localparam logic [IW-1:0] LAST = IW'(p_ninputs - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [p_nbits-1:0]  msg_q, msg_d;
  logic [IW-1:0]       gid_q, gid_d;
  logic [IW-1:0]       ptr_cur;
  logic [IW-1:0]       win;
  logic                any_vld;
  logic                load_en;
  logic                xfer;

`ifdef ROUTER_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;
  assign ptr_cur = ptr_q;
`else
  assign ptr_cur = '0;
`endif

  // Scan from the priority pointer upward, wrapping past the last requester.
  always_comb begin
    int idx;
    logic found;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < p_ninputs; k++) begin
      idx = int'(ptr_cur) + k;
      if (idx >= p_ninputs) idx = idx - p_ninputs;
      if (!found && valid_in[idx]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  assign any_vld = |valid_in;
  assign load_en = (state_q == EMPTY) || ready_in;
  assign xfer    = |ready_out;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      msg_q   <= '0;
      gid_q   <= '0;
`ifdef ROUTER_ARB_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      gid_q   <= gid_d;
`ifdef ROUTER_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    gid_d   = gid_q;
`ifdef ROUTER_ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    if (xfer) begin
      state_d = FULL;
      msg_d   = message_in[win*p_nbits +: p_nbits];
      gid_d   = win;
`ifdef ROUTER_ARB_ROUND_ROBIN_EN
      ptr_d   = (win == LAST) ? '0 : win + 1'b1;
`endif
    end else if (state_q == FULL && ready_in) begin
      state_d = EMPTY;
    end
  end

  // Output logic; ready never depends on message contents
  always_comb begin
    ready_out = '0;
    if (!reset && load_en && any_vld) ready_out[win] = 1'b1;
  end

  assign valid_out   = (state_q == FULL);
  assign message_out = msg_q;
  assign grant_id    = gid_q;

endmodule

// File: doc/router_input_arbiter.md
ROUTER_INPUT_ARBITER -- requirements
Module: router_input_arbiter

Interface
REQ-001 SHALL have parameter p_nbits, default 8: message width, address bits in MSBs, passed unchanged to the router.
REQ-002 SHALL have parameter p_ninputs, default 4: number of requesters, at least 2.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port valid_in  input  p_ninputs  per-requester valid, bit i belongs to requester i.
REQ-006 SHALL have port ready_out  output  p_ninputs  per-requester ready, bit i belongs to requester i.
REQ-007 SHALL have port message_in  input  p_nbits*p_ninputs  flattened messages; requester i occupies bits [i*p_nbits +: p_nbits].
REQ-008 SHALL have port valid_out  output  1  valid toward the router's valid input.
REQ-009 SHALL have port ready_in  input  1  ready from the router's ready_out.
REQ-010 SHALL have port message_out  output  p_nbits  buffered message toward the router's message_in.
REQ-011 SHALL have port grant_id  output  $clog2(p_ninputs)  index of the requester whose message is in the buffer.

Function
REQ-012 SHALL hold one output buffer entry with two states: EMPTY (valid_out=0) and FULL (valid_out=1).
REQ-013 SHALL define load_en = EMPTY or (FULL and ready_in), so a drain and a load can happen in the same cycle.
REQ-014 SHALL pick the winner g each cycle as the first i with valid_in[i]=1, scanning ptr, ptr+1, ... with wrap to 0 after p_ninputs-1.
REQ-015 SHALL drive ready_out one-hot at bit g when load_en=1 and any valid_in is set, and all-zero otherwise.
REQ-016 SHALL compute ready_out combinationally from valid_in, ptr, state and ready_in only, never from message_in.
REQ-017 SHALL perform a transfer when valid_in[g] and ready_out[g] are both 1.
REQ-018 On a transfer, next edge SHALL set message_out to slot g, grant_id to g, state to FULL, and ptr to (g+1) mod p_ninputs.
REQ-019 A FULL buffer with ready_in=1 and no transfer SHALL go EMPTY next edge; message_out and grant_id keep their values.
REQ-020 A FULL buffer with ready_in=0 SHALL keep valid_out, message_out and grant_id stable, and ready_out SHALL be all-zero.
REQ-021 Latency SHALL be 1 cycle from requester transfer to valid_out=1; sustained throughput SHALL be 1 message per cycle while ready_in=1.
REQ-022 ptr SHALL change only on a transfer; idle cycles leave the priority unchanged.
REQ-023 With all requesters valid and ready_in held at 1, grants SHALL cycle 0,1,...,p_ninputs-1,0 with no skips.

Reset
REQ-024 While reset=1 at a clock edge, next state SHALL be EMPTY, valid_out=0, message_out=0, grant_id=0, ptr=0.
REQ-025 While reset=1, ready_out SHALL be all-zero and no transfer SHALL occur.
REQ-026 Reset mid-operation SHALL drop any buffered message without forwarding it; the first grant after reset SHALL follow priority from index 0.

Configuration
REQ-027 Macro ROUTER_ARB_ROUND_ROBIN_EN defined: priority SHALL be round-robin per REQ-014, REQ-018 and REQ-022.
REQ-028 Macro ROUTER_ARB_ROUND_ROBIN_EN undefined: priority SHALL be fixed, lowest index wins, the ptr register SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (p_nbits=8, p_ninputs=4, macro defined unless noted)
REQ-029 Single request: valid_in=0010, slot1=0xA5, ready_in=1 -> ready_out=0010 that cycle; next cycle valid_out=1, message_out=0xA5, grant_id=1.
REQ-030 Full contention: valid_in=1111 held, ready_in=1 for 6 cycles -> grant_id sequence 0,1,2,3,0,1 with valid_out=1 every cycle after the first.
REQ-031 Backpressure: buffer FULL with 0x3C, ready_in=0 for 3 cycles -> ready_out=0000 and message_out=0x3C stable; when ready_in goes to 1, the next winner loads in that same cycle.
REQ-032 Wrap: ptr=3 and valid_in=1001 -> requester 3 is granted, then requester 0 next.
REQ-033 Reset mid-stream: buffer FULL with 0x77 and reset pulsed for 1 cycle -> valid_out=0 the next cycle, 0x77 never accepted; valid_in=1111 then grants 0 first.
REQ-034 Macro undefined: valid_in=1111 held, ready_in=1 -> grant_id stays 0 every cycle.
